fft_frame_loader: RTL

// Multi-channel framing stage between the ADC deserialiser and the radix-2 DIT FFT core.
// - Writes each channel's ADC samples into a ping-pong frame buffer at bit-reversed addresses.
// - Streams completed frames to the FFT with a valid/ready handshake.
// - Drops whole frames when the FFT side cannot keep up, and reports the drop.

---
 rtl/dsp_pkg.sv | 26 ++
 rtl/frame_bank_ram.sv | 32 +++
 rtl/fft_frame_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared defaults, the read FSM state type and the bit-reversal helper used by the frame loader.
package dsp_pkg;

   localparam int DATA_W_DEF       = 12;
   localparam int FFT_LEN_LOG2_DEF = 4;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ARB,
      RD_STREAM
   } rd_state_e;

   // Reverse the low n bits of idx; bits above n come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int n);
      logic [31:0] r;
      logic [31:0] v;
      r = '0;
      v = idx;
      for (int i = 0; i < n; i++) begin
         r = {r[30:0], v[0]};
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame store addressed {ch, bank, idx}; read data is registered and holds
// its value while re is low, so it doubles as the stream output register.
module frame_bank_ram #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Multi-channel ping-pong framer feeding a radix-2 DIT FFT in bit-reversed order.
// Define PEAK_TRACK_EN to add per-channel frame peak outputs (peak_valid, peak_data).
module fft_frame_loader
   import dsp_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int FFT_LEN_LOG2 = FFT_LEN_LOG2_DEF,
   parameter int NUM_CH       = 2,
   parameter int CNT_W        = 16,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [CH_W-1:0]     s_ch,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [2*DATA_W-1:0] m_data,
   output logic [CH_W-1:0]     m_ch,
   output logic                m_sof,
   output logic                m_eof,
   output logic                overflow,
   output logic [CNT_W-1:0]    drop_cnt
`ifdef PEAK_TRACK_EN
   ,
   output logic                     peak_valid,
   output logic [NUM_CH*DATA_W-1:0] peak_data
`endif
);

   localparam int FFT_LEN = 1 << FFT_LEN_LOG2;
   localparam int IDX_W   = FFT_LEN_LOG2;
   localparam int ADDR_W  = CH_W + 1 + IDX_W;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

   logic [NUM_CH-1:0][IDX_W-1:0] widx_q, widx_d;
   logic [NUM_CH-1:0]            wb_q, wb_d, rb_q, rb_d, seen_q, seen_d;
   logic [NUM_CH-1:0][1:0]       full_q, full_d, rel;
   logic [NUM_CH-1:0]            accept, drop, frame_done;
   logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;
   logic                         ovf_q, ovf_d;

   rd_state_e                    state_q, state_d;
   logic [CH_W-1:0]              last_ch_q, last_ch_d, cur_ch_q, cur_ch_d;
   logic                         cur_bank_q, cur_bank_d;
   logic [IDX_W-1:0]             ridx_q, ridx_d, ridx_nxt;
   logic [CH_W-1:0]              pick, cand;
   logic                         found;

   logic                         ch_ok, ram_we, ram_re;
   logic [IDX_W-1:0]             widx_rev;
   logic [ADDR_W-1:0]            waddr, raddr;
   logic [DATA_W-1:0]            rdata;

   assign ch_ok    = s_valid && ({1'b0, s_ch} < NUM_CH_L);
   assign widx_rev = IDX_W'(bitrev(32'(widx_q[s_ch]), IDX_W));
   assign ridx_nxt = ridx_q + IDX_W'(1);

   // Write side: a bank released by the reader this cycle counts as free.
   always_comb begin
      widx_d     = widx_q;
      wb_d       = wb_q;
      seen_d     = seen_q;
      full_d     = full_q & ~rel;
      accept     = '0;
      drop       = '0;
      frame_done = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_ok && (s_ch == CH_W'(c))) begin
            if (full_q[c][wb_q[c]] && !rel[c][wb_q[c]]) begin
               drop[c]   = 1'b1;
               seen_d[c] = 1'b1;
            end else begin
               accept[c] = 1'b1;
               seen_d[c] = 1'b0;
               if (widx_q[c] == IDX_LAST) begin
                  frame_done[c]        = 1'b1;
                  full_d[c][wb_q[c]]   = 1'b1;
                  wb_d[c]              = ~wb_q[c];
                  widx_d[c]            = '0;
               end else begin
                  widx_d[c] = widx_q[c] + IDX_W'(1);
               end
            end
         end
      end
   end

   assign ram_we     = |accept;
   assign waddr      = {s_ch, wb_q[s_ch], widx_rev};
   assign ovf_d      = |(drop & ~seen_q);
   assign drop_cnt_d = (|drop && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;

   // Round-robin search starting after the last served channel.
   always_comb begin
      pick  = last_ch_q;
      cand  = last_ch_q;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(last_ch_q) + i) % NUM_CH);
         if (!found && (|full_q[cand])) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ridx_d     = ridx_q;
      cur_ch_d   = cur_ch_q;
      cur_bank_d = cur_bank_q;
      last_ch_d  = last_ch_q;
      rb_d       = rb_q;
      rel        = '0;
      ram_re     = 1'b0;
      raddr      = {cur_ch_q, cur_bank_q, ridx_nxt};
      unique case (state_q)
         RD_IDLE: begin
            if (|full_q) state_d = RD_ARB;
         end
         RD_ARB: begin
            cur_ch_d   = pick;
            cur_bank_d = rb_q[pick];
            ridx_d     = '0;
            ram_re     = 1'b1;
            raddr      = {pick, rb_q[pick], {IDX_W{1'b0}}};
            state_d    = RD_STREAM;
         end
         RD_STREAM: begin
            if (m_ready) begin
               if (ridx_q == IDX_LAST) begin
                  rel[cur_ch_q][cur_bank_q] = 1'b1;
                  rb_d[cur_ch_q]            = ~rb_q[cur_ch_q];
                  last_ch_d                 = cur_ch_q;
                  state_d                   = RD_IDLE;
               end else begin
                  ridx_d = ridx_nxt;
                  ram_re = 1'b1;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx_q     <= '0;
         wb_q       <= '0;
         rb_q       <= '0;
         seen_q     <= '0;
         full_q     <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
         state_q    <= RD_IDLE;
         last_ch_q  <= CH_W'(NUM_CH - 1);
         cur_ch_q   <= '0;
         cur_bank_q <= 1'b0;
         ridx_q     <= '0;
      end else begin
         widx_q     <= widx_d;
         wb_q       <= wb_d;
         rb_q       <= rb_d;
         seen_q     <= seen_d;
         full_q     <= full_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         last_ch_q  <= last_ch_d;
         cur_ch_q   <= cur_ch_d;
         cur_bank_q <= cur_bank_d;
         ridx_q     <= ridx_d;
      end
   end

   frame_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (NUM_CH * 2 * FFT_LEN)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (waddr),
      .wdata (s_data),
      .re    (ram_re),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign m_valid  = (state_q == RD_STREAM);
   assign m_data   = {rdata, {DATA_W{1'b0}}};
   assign m_ch     = cur_ch_q;
   assign m_sof    = m_valid && (ridx_q == '0);
   assign m_eof    = m_valid && (ridx_q == IDX_LAST);
   assign overflow = ovf_q;
   assign drop_cnt = drop_cnt_q;

`ifdef PEAK_TRACK_EN
   logic [NUM_CH-1:0][DATA_W-1:0] run_q, run_d, peak_q, peak_d;
   logic [NUM_CH-1:0][DATA_W-1:0] run_nxt;
   logic                          pv_q, pv_d;

   // The running max restarts on the first accepted sample of each frame.
   always_comb begin
      run_d   = run_q;
      peak_d  = peak_q;
      run_nxt = run_q;
      pv_d    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         run_nxt[c] = ((widx_q[c] == '0) || (s_data > run_q[c])) ? s_data : run_q[c];
         if (accept[c]) run_d[c] = run_nxt[c];
         if (frame_done[c]) begin
            peak_d[c] = run_nxt[c];
            pv_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q  <= '0;
         peak_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         run_q  <= run_d;
         peak_q <= peak_d;
         pv_q   <= pv_d;
      end
   end

   assign peak_valid = pv_q;
   assign peak_data  = peak_q;
`endif

endmodule
